// File: rtl/fft_bitrev_buffer_if.sv
// Sample-write, frame-start and streaming-output signals between the bit-reverse
// address generator, the frame buffer and the first butterfly stage.
interface fft_bitrev_buffer_if #(
    parameter int unsigned bit_width = 32,
    parameter int unsigned SIZE      = 4
);
    logic [bit_width-1:0] Re_i;
    logic [bit_width-1:0] Im_i;
    logic [SIZE:0]        addr_i;
    logic                 en_i;
    logic                 start_i;
    logic                 ready_i;
    logic [bit_width-1:0] Re_o;
    logic [bit_width-1:0] Im_o;
    logic [SIZE-1:0]      idx_o;
    logic                 valid_o;
    logic                 last_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    modport master (
        output Re_i, Im_i, addr_i, en_i, start_i, ready_i,
        input  Re_o, Im_o, idx_o, valid_o, last_o, busy_o, done_o, err_o
    );

    modport slave (
        input  Re_i, Im_i, addr_i, en_i, start_i, ready_i,
        output Re_o, Im_o, idx_o, valid_o, last_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/fft_bitrev_buffer.sv
// Frame buffer: captures N samples at bit-reversed addresses, then streams the frame
// out in linear memory order over valid/ready with a one-entry read stage.
module fft_bitrev_buffer #(
    parameter int unsigned bit_width = 32,
    parameter int unsigned N         = 16,
    parameter int unsigned SIZE      = 4
) (
    input  logic             clk,
    input  logic             rst,
    fft_bitrev_buffer_if.slave bus
);
    localparam int unsigned  DW       = 2 * bit_width;
    localparam int unsigned  CW       = SIZE + 1;
    localparam logic [CW-1:0]   FULL     = CW'(N);
    localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   mem [N];
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   rd_ptr;
    logic            s1_valid;
    logic [DW-1:0]   s1_data;
    logic [SIZE-1:0] s1_idx;

    logic            wr_c;
    logic            bad_c;
    logic            drop_c;
    logic            go_c;
    logic            short_c;
    logic            issue_c;
    logic            exit_c;
    logic            out_load_c;
    logic [CW-1:0]   cnt_upd_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (go_c)   state_nxt = DRAIN;
            DRAIN:   if (exit_c) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Control decode; a same-cycle write is folded into the count before start is judged
    always_comb begin
        wr_c       = 1'b0;
        bad_c      = 1'b0;
        drop_c     = 1'b0;
        go_c       = 1'b0;
        short_c    = 1'b0;
        issue_c    = 1'b0;
        exit_c     = 1'b0;
        cnt_upd_c  = wr_cnt;
        out_load_c = !bus.valid_o || bus.ready_i;
        case (state)
            FILL: begin
                wr_c  = bus.en_i && !bus.addr_i[SIZE];
                bad_c = bus.en_i &&  bus.addr_i[SIZE];
                if (wr_c && wr_cnt != FULL) cnt_upd_c = wr_cnt + CW'(1);
                go_c    = bus.start_i && (cnt_upd_c == FULL);
                short_c = bus.start_i && (cnt_upd_c != FULL);
            end
            DRAIN: begin
                drop_c  = bus.en_i;
                issue_c = (rd_ptr != FULL) && (!s1_valid || out_load_c);
                exit_c  = bus.valid_o && bus.ready_i && bus.last_o;
            end
            default: ;
        endcase
    end

    // Frame memory and its registered read port
    always_ff @(posedge clk) begin
        if (wr_c)    mem[bus.addr_i[SIZE-1:0]] <= {bus.Re_i, bus.Im_i};
        if (issue_c) s1_data <= mem[rd_ptr[SIZE-1:0]];
    end

    // Counters, read stage and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            s1_valid    <= 1'b0;
            s1_idx      <= '0;
            bus.Re_o    <= '0;
            bus.Im_o    <= '0;
            bus.idx_o   <= '0;
            bus.valid_o <= 1'b0;
            bus.last_o  <= 1'b0;
            bus.busy_o  <= 1'b0;
            bus.done_o  <= 1'b0;
            bus.err_o   <= 1'b0;
        end else begin
            bus.done_o <= exit_c;
            bus.err_o  <= bad_c || short_c || drop_c;
            bus.busy_o <= (state_nxt == DRAIN);

            if (state == FILL)  wr_cnt <= short_c ? '0 : cnt_upd_c;
            else if (exit_c)    wr_cnt <= '0;

            if (go_c)         rd_ptr <= '0;
            else if (issue_c) rd_ptr <= rd_ptr + CW'(1);

            if (issue_c) begin
                s1_valid <= 1'b1;
                s1_idx   <= rd_ptr[SIZE-1:0];
            end else if (out_load_c) begin
                s1_valid <= 1'b0;
            end

            // Output only advances when empty or the current sample is being taken
            if (out_load_c) begin
                bus.valid_o <= s1_valid;
                bus.last_o  <= s1_valid && (s1_idx == LAST_IDX);
                if (s1_valid) begin
                    bus.Re_o  <= s1_data[DW-1:bit_width];
                    bus.Im_o  <= s1_data[bit_width-1:0];
                    bus.idx_o <= s1_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Directed bench for fft_bitrev_buffer: full frames, backpressure, short frames,
// bad addresses, writes during drain and reset mid-drain.
module tb_fft_bitrev_buffer;
    localparam int unsigned BW   = 32;
    localparam int unsigned N    = 16;
    localparam int unsigned SIZE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_bitrev_buffer_if #(.bit_width(BW), .SIZE(SIZE)) ifc ();

    fft_bitrev_buffer #(.bit_width(BW), .N(N), .SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW-1:0]   cap_re   [N];
    logic [BW-1:0]   cap_im   [N];
    logic [SIZE-1:0] cap_idx  [N];
    logic            cap_last [N];
    int n_xfer, n_done, n_err, n_unstable, first_valid, last_cyc, done_cyc, busy_gap, busy_after;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Sample k was written at bitrev(k), so memory index i holds sample bitrev(i)
    function automatic logic [BW-1:0] exp_re(input int idx, input int tag);
        return BW'(int'(bitrev4(4'(idx))) * 64 + tag);
    endfunction

    function automatic logic [BW-1:0] exp_im(input int idx, input int tag);
        return BW'(0) - exp_re(idx, tag);
    endfunction

    function automatic logic rdy(input int mode, input int cyc);
        return (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
    endfunction

    task automatic fill_frame(input int tag, input int cnt, input bit start_last);
        for (int k = 0; k < cnt; k++) begin
            ifc.en_i    = 1'b1;
            ifc.addr_i  = {1'b0, bitrev4(4'(k))};
            ifc.Re_i    = BW'(k * 64 + tag);
            ifc.Im_i    = BW'(0) - BW'(k * 64 + tag);
            ifc.start_i = start_last && (k == cnt - 1);
            @(posedge clk); #1;
        end
        ifc.en_i    = 1'b0;
        ifc.start_i = 1'b0;
    endtask

    task automatic pulse_start();
        ifc.start_i = 1'b1;
        @(posedge clk); #1;
        ifc.start_i = 1'b0;
    endtask

    // Runs one drain, recording every transfer; cyc 0 is the cycle after the start edge
    task automatic drain(input int mode, input int inj_after, input int rst_after, input bit do_start);
        bit hold_v, inj_pend, stop;
        logic [BW-1:0]   h_re, h_im;
        logic [SIZE-1:0] h_idx;
        n_xfer = 0; n_done = 0; n_err = 0; n_unstable = 0;
        first_valid = -1; last_cyc = -1; done_cyc = -1; busy_gap = 0; busy_after = -1;
        hold_v = 1'b0; inj_pend = 1'b0; stop = 1'b0;
        h_re = '0; h_im = '0; h_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            cap_re[i] = 'x; cap_im[i] = 'x; cap_idx[i] = 'x; cap_last[i] = 1'bx;
        end
        ifc.ready_i = rdy(mode, 0);
        if (do_start) pulse_start();
        for (int cyc = 0; cyc < 120 && !stop; cyc++) begin
            ifc.ready_i = rdy(mode, cyc);
            if (inj_pend) begin
                ifc.en_i   = 1'b1;
                ifc.addr_i = 5'd12;
                ifc.Re_i   = 32'hDEAD_BEEF;
                ifc.Im_i   = 32'h0BAD_F00D;
                inj_pend   = 1'b0;
            end
            @(negedge clk);
            if (ifc.valid_o && first_valid < 0) first_valid = cyc;
            if (hold_v && (!ifc.valid_o || ifc.Re_o !== h_re || ifc.Im_o !== h_im || ifc.idx_o !== h_idx))
                n_unstable++;
            hold_v = ifc.valid_o && !ifc.ready_i;
            h_re = ifc.Re_o; h_im = ifc.Im_o; h_idx = ifc.idx_o;
            if (ifc.done_o) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc   = cyc;
                    busy_after = int'(ifc.busy_o);
                end
            end
            if (ifc.err_o) n_err++;
            if (last_cyc < 0 && !ifc.busy_o) busy_gap++;
            if (ifc.valid_o && ifc.ready_i) begin
                if (n_xfer < int'(N)) begin
                    cap_re[n_xfer]   = ifc.Re_o;
                    cap_im[n_xfer]   = ifc.Im_o;
                    cap_idx[n_xfer]  = ifc.idx_o;
                    cap_last[n_xfer] = ifc.last_o;
                end
                if (ifc.last_o && last_cyc < 0) last_cyc = cyc;
                n_xfer++;
                if (n_xfer == inj_after) inj_pend = 1'b1;
                if (n_xfer == rst_after) stop = 1'b1;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) stop = 1'b1;
            @(posedge clk); #1;
            ifc.en_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        ifc.Re_i = '0; ifc.Im_i = '0; ifc.addr_i = '0;
        ifc.en_i = 1'b0; ifc.start_i = 1'b0; ifc.ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ifc.valid_o, ifc.last_o, ifc.busy_o, ifc.done_o, ifc.err_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got v/l/b/d/e=%b want 00000",
                     {ifc.valid_o, ifc.last_o, ifc.busy_o, ifc.done_o, ifc.err_o});
        end
        n_checks++;
        if (ifc.Re_o !== '0 || ifc.Im_o !== '0 || ifc.idx_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got re=%h im=%h idx=%0d want all 0", ifc.Re_o, ifc.Im_o, ifc.idx_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        fill_frame(0, 16, 1'b0);
        drain(0, -1, -1, 1'b1);
        n_checks++;
        if (first_valid !== 2) begin n_fail++; $display("FAIL full_latency: got %0d want 2", first_valid); end
        n_checks++;
        if (n_xfer !== 16) begin n_fail++; $display("FAIL full_count: got %0d want 16", n_xfer); end
        for (int i = 0; i < int'(N); i++) begin
            n_checks++;
            if (cap_idx[i] !== SIZE'(i) || cap_re[i] !== exp_re(i, 0) || cap_im[i] !== exp_im(i, 0)) begin
                n_fail++;
                $display("FAIL full_sample %0d: got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                         i, cap_idx[i], cap_re[i], cap_im[i], i, exp_re(i, 0), exp_im(i, 0));
            end
            n_checks++;
            if (cap_last[i] !== (i == 15)) begin
                n_fail++; $display("FAIL full_last %0d: got %b want %b", i, cap_last[i], (i == 15));
            end
        end
        n_checks++;
        if (last_cyc !== 17) begin n_fail++; $display("FAIL full_last_cycle: got %0d want 17", last_cyc); end
        n_checks++;
        if (n_done !== 1 || done_cyc !== 18) begin
            n_fail++; $display("FAIL full_done: got count=%0d cyc=%0d want count=1 cyc=18", n_done, done_cyc);
        end
        n_checks++;
        if (busy_gap !== 0 || busy_after !== 0) begin
            n_fail++; $display("FAIL full_busy: got gap=%0d after=%0d want 0 0", busy_gap, busy_after);
        end
        n_checks++;
        if (n_err !== 0) begin n_fail++; $display("FAIL full_err: got %0d want 0", n_err); end
    endtask

    task automatic test_backpressure();
        fill_frame(5, 16, 1'b0);
        drain(1, -1, -1, 1'b1);
        n_checks++;
        if (n_xfer !== 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", n_xfer); end
        for (int i = 0; i < int'(N); i++) begin
            n_checks++;
            if (cap_idx[i] !== SIZE'(i) || cap_re[i] !== exp_re(i, 5) || cap_im[i] !== exp_im(i, 5)) begin
                n_fail++;
                $display("FAIL bp_sample %0d: got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                         i, cap_idx[i], cap_re[i], cap_im[i], i, exp_re(i, 5), exp_im(i, 5));
            end
        end
        n_checks++;
        if (n_unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", n_unstable); end
        n_checks++;
        if (n_done !== 1 || done_cyc !== last_cyc + 1) begin
            n_fail++; $display("FAIL bp_done: got count=%0d cyc=%0d want count=1 cyc=%0d", n_done, done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_short_frame();
        int errs, valids, busys;
        errs = 0; valids = 0; busys = 0;
        ifc.ready_i = 1'b1;
        fill_frame(9, 10, 1'b0);
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            errs += int'(ifc.err_o); valids += int'(ifc.valid_o); busys += int'(ifc.busy_o);
            @(posedge clk); #1;
        end
        n_checks++;
        if (errs !== 1 || valids !== 0 || busys !== 0) begin
            n_fail++; $display("FAIL short_frame: got err=%0d valid=%0d busy=%0d want 1 0 0", errs, valids, busys);
        end
        fill_frame(11, 16, 1'b0);
        drain(0, -1, -1, 1'b1);
        n_checks++;
        if (n_xfer !== 16 || n_err !== 0) begin
            n_fail++; $display("FAIL short_recover: got xfers=%0d err=%0d want 16 0", n_xfer, n_err);
        end
        for (int i = 0; i < int'(N); i++) begin
            n_checks++;
            if (cap_idx[i] !== SIZE'(i) || cap_re[i] !== exp_re(i, 11) || cap_im[i] !== exp_im(i, 11)) begin
                n_fail++;
                $display("FAIL short_sample %0d: got idx=%0d re=%h want idx=%0d re=%h",
                         i, cap_idx[i], cap_re[i], i, exp_re(i, 11));
            end
        end
    endtask

    task automatic test_bad_addr();
        int errs, valids;
        errs = 0; valids = 0;
        // A bad write must not count: 15 good + 1 bad is still a short frame
        fill_frame(13, 15, 1'b0);
        ifc.en_i = 1'b1; ifc.addr_i = 5'b10011; ifc.Re_i = 32'h7777; ifc.Im_i = 32'h7777;
        @(posedge clk); #1;
        ifc.en_i = 1'b0; ifc.start_i = 1'b1;
        @(negedge clk);
        errs += int'(ifc.err_o);
        @(posedge clk); #1;
        ifc.start_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            errs += int'(ifc.err_o); valids += int'(ifc.valid_o);
            @(posedge clk); #1;
        end
        n_checks++;
        if (errs !== 2 || valids !== 0) begin
            n_fail++; $display("FAIL bad_addr_count: got err=%0d valid=%0d want 2 0", errs, valids);
        end
        // A bad write after a full fill must not disturb index 3
        fill_frame(17, 16, 1'b0);
        ifc.en_i = 1'b1; ifc.addr_i = 5'b10011; ifc.Re_i = 32'h7777; ifc.Im_i = 32'h7777;
        @(posedge clk); #1;
        ifc.en_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifc.err_o !== 1'b1) begin n_fail++; $display("FAIL bad_addr_err: got %b want 1", ifc.err_o); end
        @(posedge clk); #1;
        drain(0, -1, -1, 1'b1);
        n_checks++;
        if (n_xfer !== 16 || n_err !== 0) begin
            n_fail++; $display("FAIL bad_addr_drain: got xfers=%0d err=%0d want 16 0", n_xfer, n_err);
        end
        for (int i = 0; i < int'(N); i++) begin
            n_checks++;
            if (cap_idx[i] !== SIZE'(i) || cap_re[i] !== exp_re(i, 17) || cap_im[i] !== exp_im(i, 17)) begin
                n_fail++;
                $display("FAIL bad_addr_sample %0d: got idx=%0d re=%h want idx=%0d re=%h",
                         i, cap_idx[i], cap_re[i], i, exp_re(i, 17));
            end
        end
    endtask

    task automatic test_write_in_drain();
        fill_frame(21, 16, 1'b0);
        drain(0, 5, -1, 1'b1);
        n_checks++;
        if (n_xfer !== 16 || n_err !== 1 || n_done !== 1) begin
            n_fail++; $display("FAIL drain_write: got xfers=%0d err=%0d done=%0d want 16 1 1", n_xfer, n_err, n_done);
        end
        for (int i = 0; i < int'(N); i++) begin
            n_checks++;
            if (cap_idx[i] !== SIZE'(i) || cap_re[i] !== exp_re(i, 21) || cap_im[i] !== exp_im(i, 21)) begin
                n_fail++;
                $display("FAIL drain_write_sample %0d: got idx=%0d re=%h want idx=%0d re=%h",
                         i, cap_idx[i], cap_re[i], i, exp_re(i, 21));
            end
        end
    endtask

    task automatic test_back_to_back();
        int errs, valids;
        errs = 0; valids = 0;
        // Start shares the cycle with the 16th write; a write lands in the drain-exit cycle
        fill_frame(25, 16, 1'b1);
        drain(0, 15, -1, 1'b0);
        n_checks++;
        if (first_valid !== 2 || n_xfer !== 16) begin
            n_fail++; $display("FAIL b2b_drain: got latency=%0d xfers=%0d want 2 16", first_valid, n_xfer);
        end
        n_checks++;
        if (n_err !== 1 || n_done !== 1) begin
            n_fail++; $display("FAIL b2b_exit_write: got err=%0d done=%0d want 1 1", n_err, n_done);
        end
        for (int i = 0; i < int'(N); i++) begin
            n_checks++;
            if (cap_idx[i] !== SIZE'(i) || cap_re[i] !== exp_re(i, 25) || cap_im[i] !== exp_im(i, 25)) begin
                n_fail++;
                $display("FAIL b2b_sample %0d: got idx=%0d re=%h want idx=%0d re=%h",
                         i, cap_idx[i], cap_re[i], i, exp_re(i, 25));
            end
        end
        // The dropped exit-cycle write must not have counted toward the next frame
        fill_frame(27, 15, 1'b0);
        pulse_start();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            errs += int'(ifc.err_o); valids += int'(ifc.valid_o);
            @(posedge clk); #1;
        end
        n_checks++;
        if (errs !== 1 || valids !== 0) begin
            n_fail++; $display("FAIL b2b_count: got err=%0d valid=%0d want 1 0", errs, valids);
        end
    endtask

    task automatic test_reset_mid_drain();
        fill_frame(29, 16, 1'b0);
        drain(0, -1, 7, 1'b1);
        n_checks++;
        if (n_xfer !== 7) begin n_fail++; $display("FAIL rst_pre_count: got %0d want 7", n_xfer); end
        ifc.ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifc.valid_o !== 1'b0 || ifc.busy_o !== 1'b0 || ifc.done_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: got valid=%b busy=%b done=%b want 0 0 0",
                               ifc.valid_o, ifc.busy_o, ifc.done_o);
        end
        @(posedge clk); #1;
        fill_frame(31, 16, 1'b0);
        drain(0, -1, -1, 1'b1);
        n_checks++;
        if (first_valid !== 2 || n_xfer !== 16 || n_err !== 0) begin
            n_fail++; $display("FAIL rst_recover: got latency=%0d xfers=%0d err=%0d want 2 16 0",
                               first_valid, n_xfer, n_err);
        end
        for (int i = 0; i < int'(N); i++) begin
            n_checks++;
            if (cap_idx[i] !== SIZE'(i) || cap_re[i] !== exp_re(i, 31) || cap_im[i] !== exp_im(i, 31)) begin
                n_fail++;
                $display("FAIL rst_sample %0d: got idx=%0d re=%h want idx=%0d re=%h",
                         i, cap_idx[i], cap_re[i], i, exp_re(i, 31));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_short_frame();
        test_bad_addr();
        test_write_in_drain();
        test_back_to_back();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fft_bitrev_buffer.md
Name: fft_bitrev_buffer

Overview:
- Sits directly downstream of the UART sample de-serializer / bit-reverse address generator.
- Captures N complex samples, each written at its already bit-reversed address, into an internal frame memory.
- On the de-serializer's frame-complete pulse, streams the frame out in linear memory order (i.e. bit-reversed sample order) to the first radix-2 butterfly stage over a valid/ready handshake.
- Guards against short frames and against writes that arrive while a frame is draining.

Parameters:
- bit_width, 32, width of each Re/Im sample (two's complement).
- N, 16, frame length in complex samples; must equal 2**SIZE.
- SIZE, 4, address bits (log2 N).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- Re_i  in  bit_width  real part of incoming sample.
- Im_i  in  bit_width  imaginary part of incoming sample.
- addr_i  in  SIZE+1  bit-reversed write address; bit SIZE must be 0.
- en_i  in  1  one-cycle write strobe for Re_i/Im_i/addr_i.
- start_i  in  1  one-cycle frame-complete pulse from upstream.
- ready_i  in  1  downstream butterfly can accept a sample.
- Re_o  out  bit_width  real part of output sample.
- Im_o  out  bit_width  imaginary part of output sample.
- idx_o  out  SIZE  memory index of the current output sample.
- valid_o  out  1  Re_o/Im_o/idx_o are valid.
- last_o  out  1  current output is index N-1.
- busy_o  out  1  high in DRAIN.
- done_o  out  1  one-cycle pulse after the last output is accepted.
- err_o  out  1  one-cycle pulse on a short frame, bad address, or a write during DRAIN.

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-drain):
  - State returns to FILL.
  - Write count, read pointer, valid_o, last_o, busy_o, done_o and err_o go to 0.
  - Re_o, Im_o and idx_o go to 0.
  - Memory contents are not cleared.
- Memory: N x (2*bit_width); synchronous write, registered read.
- State machine, FILL:
  - When en_i=1 and addr_i[SIZE]=0: write mem[addr_i[SIZE-1:0]] <= {Re_i, Im_i} and increment wr_cnt. wr_cnt is SIZE+1 bits and saturates at N.
  - When en_i=1 and addr_i[SIZE]=1: no write, no count change, err_o pulses.
  - A repeated address overwrites the earlier sample and still increments the count.
- State machine, FILL with start_i=1:
  - If en_i and start_i are high in the same cycle, the write is applied first, then start_i is evaluated using the updated count.
  - Updated count == N: go to DRAIN and set rd_ptr=0.
  - Otherwise: short frame. err_o pulses, wr_cnt clears, state stays FILL, and no data is output.
- State machine, DRAIN:
  - busy_o=1.
  - The first valid_o=1 appears exactly 2 cycles after the start_i edge (read latency 1), carrying mem[0] with idx_o=0.
  - Output registers reload only when valid_o=0 or (valid_o && ready_i).
  - A transfer occurs when valid_o && ready_i. Re_o/Im_o/idx_o stay stable while valid_o && !ready_i.
  - With ready_i held high, one sample is output per cycle with no bubbles after the first.
  - last_o = valid_o && idx_o==N-1.
  - The transfer with last_o=1 moves the state to FILL on the same edge: valid_o drops, wr_cnt clears, and done_o pulses for one cycle in the following cycle.
  - Any en_i during DRAIN: sample dropped, err_o pulses, and the drain continues unaffected.
  - start_i during DRAIN is ignored.
- A write arriving in the same cycle that DRAIN exits to FILL is dropped and err_o pulses. Writes are accepted from the next cycle on.
- ready_i low in FILL has no effect.

Test Plan:
- Fill addresses 0,8,4,12,...,15 (bit-reverse of 0..15), with Re=k*64 and Im=-(k*64) for write number k, then start_i, ready_i=1 -> valid_o high 2 cycles after start. Sixteen consecutive outputs at idx_o 0..15 with Re_o = 64*bitrev(idx). last_o only at idx 15; done_o pulses one cycle later.
- Same frame with ready_i toggling 1,0,0,1 repeating -> no sample lost or duplicated, outputs held stable while ready_i=0, 16 transfers total.
- Only 10 writes then start_i -> err_o pulses once, valid_o never asserts, busy_o stays 0. A following full 16-write frame drains correctly.
- en_i with addr_i=5'b10011 -> err_o pulses, count unchanged; a subsequent full frame drains normally.
- During DRAIN, after 5 transfers, assert en_i -> err_o pulses and the remaining 11 outputs match the original frame contents.
- rst=1 asserted for one cycle after 7 transfers -> next cycle valid_o=0, busy_o=0, state FILL. A new 16-sample frame then drains from idx_o=0.
